ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the 5-stage RISC-V core. It sits directly downstream of the ID/EX register and the EX-stage ALU, and feeds data memory and the MEM/WB register.
- Latches the ALU result, store data, destination register and the WB/M control fields. Computes and registers the branch target.
- Resolves the branch decision (PCSrc) in MEM and squashes the wrong-path instruction entering from EX on a taken branch.

Parameters:
- XLEN, 64, datapath width (addresses, ALU result, store data).
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all registered outputs (MEM stage busy).
- flush  in  1  squash the incoming instruction (insert bubble).
- valid_in  in  1  EX-stage instruction is real (not a bubble).
- Inst_Addr  in  XLEN  PC of the EX instruction.
- ImmediateData  in  XLEN  sign-extended immediate.
- ALU_Result  in  XLEN  ALU output.
- Zero  in  1  ALU zero flag.
- ReadData2  in  XLEN  forwarded rs2 value (store data).
- rd  in  5  destination register.
- WB  in  2  {RegWrite, MemtoReg}.
- M  in  3  {Branch, MemRead, MemWrite}.
- Branch_Target_Out  out  XLEN  registered branch target.
- ALU_Result_Out  out  XLEN  registered ALU result (memory address).
- Zero_Out  out  1  registered zero flag.
- WriteData_Out  out  XLEN  registered store data.
- rd_Out  out  5  registered rd.
- WB_Out  out  2  registered WB control.
- MemRead  out  1  registered M[1].
- MemWrite  out  1  registered M[0].
- valid_Out  out  1  MEM-stage instruction is real.
- PCSrc  out  1  branch taken in MEM; drives PC mux and upstream flushes.
- perf_insn_cnt  out  CNT_W  valid instructions accepted (optional feature).
- perf_br_cnt  out  CNT_W  taken branches (optional feature).

Behaviour:
- All state updates on the rising edge of clk.
- Priority, highest first: reset > squash > stall > load.
- Squash condition: flush | PCSrc (current registered value).
- Reset:
  - All outputs and internal registers go to 0, including PCSrc and the counters.
  - Reset asserted mid-stall or mid-branch clears everything; there is no carry-over.
- Squash:
  - Register a bubble: WB_Out=0, MemRead=0, MemWrite=0, Branch bit=0, valid_Out=0, rd_Out=0.
  - Data registers go to 0.
  - PCSrc therefore deasserts on the next cycle. A taken branch is a single-cycle PCSrc pulse and cannot retrigger.
  - A squash overrides a concurrent stall.
- Stall (without squash): every register holds its value, and PCSrc holds with it.
- Load: all fields take their inputs, with these rules:
  - Branch_Target_Out <= Inst_Addr + (ImmediateData << 1), computed modulo 2^XLEN (wraps, no overflow flag).
  - If valid_in=0, control fields (WB, M, Branch) are forced to 0 while data is still captured.
- PCSrc = Branch_reg & Zero_Out & valid_Out. It is combinational from registered state only, with zero input-to-output combinational path.
- Latency: 1 cycle from the EX inputs to every registered output.
- Simultaneous flush and PCSrc: result is a bubble, the same as either alone.

Optional Feature:
- Macro EX_MEM_PERF_CNT_EN.
- Defined:
  - perf_insn_cnt increments on every load edge with valid_in=1 and no squash or stall.
  - perf_br_cnt increments on every cycle PCSrc=1 and stall=0.
  - Both saturate at 2^CNT_W-1, with no wrap.
  - Both clear on reset.
- Undefined: both outputs are tied to 0, and no counter flops are synthesised.

Test Plan:
- Reset: load arbitrary values, then assert reset for 1 cycle -> all outputs 0 next cycle, including PCSrc=0.
- Branch target wrap: Inst_Addr=0xFFFFFFFFFFFFFFF8, Imm=8, valid -> Branch_Target_Out=0x0000000000000008.
- Taken branch: M=3'b100, Zero=1, valid_in=1 -> PCSrc=1 for exactly 1 cycle. The instruction presented during that cycle (WB=2'b10, rd=7) is squashed: next cycle WB_Out=0, rd_Out=0, valid_Out=0.
- Not-taken and bubble: M=3'b100 with Zero=0 -> PCSrc=0. valid_in=0 with M=3'b010 -> MemRead=0, ALU_Result_Out still captured.
- Stall vs flush: stall=1 for 3 cycles -> outputs unchanged. stall=1 and flush=1 together -> bubble registered.
- EX_MEM_PERF_CNT_EN on:
  - 5 valid loads plus 1 taken branch -> perf_insn_cnt=5 (squashed wrong-path instruction not counted), perf_br_cnt=1.
  - With CNT_W=2, 5 loads -> perf_insn_cnt=3 (saturated).

Source files
------------

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with MEM-stage branch resolution
// Optional performance counters are built only when EX_MEM_PERF_CNT_EN is defined.
module ex_mem_reg #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [XLEN-1:0]  Inst_Addr,
    input  logic [XLEN-1:0]  ImmediateData,
    input  logic [XLEN-1:0]  ALU_Result,
    input  logic             Zero,
    input  logic [XLEN-1:0]  ReadData2,
    input  logic [4:0]       rd,
    input  logic [1:0]       WB,
    input  logic [2:0]       M,
    output logic [XLEN-1:0]  Branch_Target_Out,
    output logic [XLEN-1:0]  ALU_Result_Out,
    output logic             Zero_Out,
    output logic [XLEN-1:0]  WriteData_Out,
    output logic [4:0]       rd_Out,
    output logic [1:0]       WB_Out,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             valid_Out,
    output logic             PCSrc,
    output logic [CNT_W-1:0] perf_insn_cnt,
    output logic [CNT_W-1:0] perf_br_cnt
);

    logic branch_q;
    logic squash;

    // A taken branch in MEM kills the wrong-path instruction coming from EX.
    assign squash = flush | PCSrc;
    assign PCSrc  = branch_q & Zero_Out & valid_Out;

    always_ff @(posedge clk) begin
        if (reset || squash) begin
            Branch_Target_Out <= '0;
            ALU_Result_Out    <= '0;
            Zero_Out          <= 1'b0;
            WriteData_Out     <= '0;
            rd_Out            <= '0;
            WB_Out            <= '0;
            MemRead           <= 1'b0;
            MemWrite          <= 1'b0;
            branch_q          <= 1'b0;
            valid_Out         <= 1'b0;
        end else if (!stall) begin
            Branch_Target_Out <= Inst_Addr + (ImmediateData << 1);
            ALU_Result_Out    <= ALU_Result;
            Zero_Out          <= Zero;
            WriteData_Out     <= ReadData2;
            rd_Out            <= rd;
            // Bubbles still carry data but must never write or branch.
            WB_Out            <= valid_in ? WB : 2'b00;
            MemRead           <= valid_in & M[1];
            MemWrite          <= valid_in & M[0];
            branch_q          <= valid_in & M[2];
            valid_Out         <= valid_in;
        end
    end

`ifdef EX_MEM_PERF_CNT_EN
    logic [CNT_W-1:0] insn_q;
    logic [CNT_W-1:0] br_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            insn_q <= '0;
            br_q   <= '0;
        end else begin
            if (valid_in && !squash && !stall && (insn_q != {CNT_W{1'b1}}))
                insn_q <= insn_q + 1'b1;
            if (PCSrc && !stall && (br_q != {CNT_W{1'b1}}))
                br_q <= br_q + 1'b1;
        end
    end

    assign perf_insn_cnt = insn_q;
    assign perf_br_cnt   = br_q;
`else
    assign perf_insn_cnt = '0;
    assign perf_br_cnt   = '0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - scoreboard bench for ex_mem_reg against a rule-level reference model
module tb_ex_mem_reg;
    localparam int XL = 64;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset, stall, flush, valid_in, Zero;
    logic [XL-1:0] Inst_Addr, ImmediateData, ALU_Result, ReadData2;
    logic [4:0] rd;
    logic [1:0] WB;
    logic [2:0] M;
    logic [XL-1:0] Branch_Target_Out, ALU_Result_Out, WriteData_Out;
    logic Zero_Out, MemRead, MemWrite, valid_Out, PCSrc;
    logic [4:0] rd_Out;
    logic [1:0] WB_Out;
    logic [CW-1:0] perf_insn_cnt, perf_br_cnt;

    ex_mem_reg #(.XLEN(XL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .Inst_Addr(Inst_Addr), .ImmediateData(ImmediateData), .ALU_Result(ALU_Result),
        .Zero(Zero), .ReadData2(ReadData2), .rd(rd), .WB(WB), .M(M),
        .Branch_Target_Out(Branch_Target_Out), .ALU_Result_Out(ALU_Result_Out),
        .Zero_Out(Zero_Out), .WriteData_Out(WriteData_Out), .rd_Out(rd_Out),
        .WB_Out(WB_Out), .MemRead(MemRead), .MemWrite(MemWrite), .valid_Out(valid_Out),
        .PCSrc(PCSrc), .perf_insn_cnt(perf_insn_cnt), .perf_br_cnt(perf_br_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XL-1:0] bt, alu;
        logic          z;
        logic [XL-1:0] wd;
        logic [4:0]    rd;
        logic [1:0]    wb;
        logic          mr, mw, br, v;
        logic [CW-1:0] ic, bc;
    } st_t;

    typedef logic [3*XL+1+5+2+4+2*CW-1:0] obs_t;

    st_t m;
    st_t sb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    function automatic logic taken(input st_t s);
        return s.br && s.z && s.v;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == {CW{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Next architectural state from the stage rules: reset, then kill, then hold, then capture.
    task automatic step(input logic r, st, fl, v, input logic [XL-1:0] pc, imm, alu,
                        input logic z, input logic [XL-1:0] d2, input logic [4:0] rdv,
                        input logic [1:0] wbv, input logic [2:0] mv);
        st_t n;
        logic kill;
        @(negedge clk);
        reset = r; stall = st; flush = fl; valid_in = v; Inst_Addr = pc;
        ImmediateData = imm; ALU_Result = alu; Zero = z; ReadData2 = d2;
        rd = rdv; WB = wbv; M = mv;
        kill = fl || taken(m);
        n = m;
        if (r) begin
            n = '0;
        end else begin
`ifdef EX_MEM_PERF_CNT_EN
            if (v && !kill && !st) n.ic = sat_inc(m.ic);
            if (taken(m) && !st) n.bc = sat_inc(m.bc);
`endif
            if (kill) begin
                n = '0;
                n.ic = (v && !kill && !st) ? sat_inc(m.ic) : m.ic;
`ifdef EX_MEM_PERF_CNT_EN
                n.bc = (taken(m) && !st) ? sat_inc(m.bc) : m.bc;
`else
                n.ic = '0;
`endif
            end else if (!st) begin
                n.bt  = pc + imm * 2;
                n.alu = alu;
                n.z   = z;
                n.wd  = d2;
                n.rd  = rdv;
                n.wb  = v ? wbv : 2'b00;
                n.mr  = v && mv[1];
                n.mw  = v && mv[0];
                n.br  = v && mv[2];
                n.v   = v;
            end
        end
        m = n;
        sb.push_back(n);
    endtask

    task automatic load(input logic [XL-1:0] pc, imm, alu, input logic z,
                        input logic [4:0] rdv, input logic [1:0] wbv, input logic [2:0] mv);
        step(1'b0, 1'b0, 1'b0, 1'b1, pc, imm, alu, z, alu ^ 64'h5A5A, rdv, wbv, mv);
    endtask

    task automatic rnd_step();
        logic [XL-1:0] a, b, c, d;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        c = {$urandom, $urandom}; d = {$urandom, $urandom};
        step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 80,
             a, b, c, $urandom_range(0, 1) == 1, d,
             5'($urandom), 2'($urandom), 3'($urandom));
    endtask

    always @(posedge clk) begin
        st_t e;
        obs_t exp_o, act_o;
        #1;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_o = {e.bt, e.alu, e.z, e.wd, e.rd, e.wb, e.mr, e.mw, e.v, taken(e), e.ic, e.bc};
            act_o = {Branch_Target_Out, ALU_Result_Out, Zero_Out, WriteData_Out, rd_Out,
                     WB_Out, MemRead, MemWrite, valid_Out, PCSrc, perf_insn_cnt, perf_br_cnt};
            checks++;
            if (act_o !== exp_o) begin
                failures++;
                $display("FAIL cycle_%0d actual=%h required=%h", cyc, act_o, exp_o);
            end
        end
    end

    initial begin
        m = '0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0; Zero = 1'b0;
        Inst_Addr = '0; ImmediateData = '0; ALU_Result = '0; ReadData2 = '0;
        rd = '0; WB = '0; M = '0;
        repeat (2) step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        load(64'h1000, 64'h20, 64'hDEAD_BEEF, 1'b1, 5'd3, 2'b11, 3'b011);
        load(64'h2000, 64'h40, 64'hCAFE, 1'b0, 5'd9, 2'b10, 3'b001);
        step(1'b1, 1, 0, 1, 64'h3000, 64'h4, 64'h77, 1, 64'h88, 5'd4, 2'b11, 3'b111);

        load(64'hFFFF_FFFF_FFFF_FFF8, 64'd8, 64'h10, 1'b0, 5'd1, 2'b10, 3'b000);

        load(64'h4000, 64'h100, 64'h0, 1'b1, 5'd2, 2'b00, 3'b100);
        load(64'h4004, 64'h0, 64'h55, 1'b0, 5'd7, 2'b10, 3'b000);
        load(64'h4008, 64'h0, 64'h66, 1'b0, 5'd8, 2'b10, 3'b000);

        load(64'h5000, 64'h10, 64'h1, 1'b0, 5'd5, 2'b00, 3'b100);
        step(1'b0, 0, 0, 0, 64'h5004, 64'h0, 64'h1234, 0, 64'h9, 5'd6, 2'b11, 3'b010);

        load(64'h6000, 64'h8, 64'hABCD, 1'b1, 5'd10, 2'b11, 3'b010);
        repeat (3) step(1'b0, 1, 0, 1, 64'h7000, 64'h8, 64'h9999, 0, 64'h1, 5'd11, 2'b10, 3'b001);
        step(1'b0, 1, 1, 1, 64'h7000, 64'h8, 64'h9999, 0, 64'h1, 5'd11, 2'b10, 3'b001);

        step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            load(64'h8000 + 64'(i * 4), 64'h0, 64'(i), 1'b0, 5'(i + 1), 2'b10, 3'b000);
        load(64'h8010, 64'h40, 64'h0, 1'b1, 5'd0, 2'b00, 3'b100);
        load(64'h8014, 64'h0, 64'h77, 1'b0, 5'd7, 2'b10, 3'b000);
        load(64'h8018, 64'h0, 64'h78, 1'b0, 5'd8, 2'b10, 3'b000);
        load(64'h801C, 64'h0, 64'h79, 1'b0, 5'd9, 2'b10, 3'b000);

        for (int i = 0; i < 600; i++) rnd_step();

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
